vram_arbiter: RTL and testbench

Time-multiplexes the single port of the text-mode VRAM between the VGA character fetch and CPU write requests from the GPIO bus. VGA reads are scheduled from the scan counters at fixed character slots. CPU writes are buffered in a small FIFO and drained in the remaining cycles. The block sits between the CPU/GPIO bridge and the VRAM and drives the VRAM address, write enable and write data. The latched character code goes to the font ROM stage.

---
 rtl/vram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM port arbiter: VGA character fetch slots plus buffered CPU writes
//
// Purpose:
//   Shares the single VRAM port between the VGA character fetch and CPU writes.
//   A read slot occurs on every eighth pixel of the visible area. CPU writes are
//   queued in a small FIFO and drained in all other cycles.
//   Optional feature macro: VRAM_SCROLL_EN (adds scroll_row, rotates the row index).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   x, y                VGA pixel column / line counters
//   cpu_we/waddr/wdata  one-cycle CPU write request
//   cpu_full            FIFO holds FIFO_DEPTH entries
//   fifo_empty          FIFO holds no entries
//   overflow            sticky dropped-push flag
//   vram_addr/we/wdata  registered VRAM port controls
//   vram_rdata          VRAM read data, one cycle after the address
//   char_data           last fetched character word
//   char_valid          one-cycle strobe marking a char_data update
//   scroll_row          top display row (VRAM_SCROLL_EN only)

module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        cpu_we,
  input  logic [15:0] cpu_waddr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_full,
  output logic        fifo_empty,
  output logic        overflow,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [15:0] vram_wdata,
  input  logic [15:0] vram_rdata,
  output logic [15:0] char_data,
`ifdef VRAM_SCROLL_EN
  output logic        char_valid,
  input  logic [5:0]  scroll_row
`else
  output logic        char_valid
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [10:0]   H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [15:0]   COLS_W   = 16'(COLS);

  logic [15:0] addr_mem [FIFO_DEPTH];
  logic [15:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   vram_addr_q, vram_addr_d;
  logic          vram_we_q, vram_we_d;
  logic [15:0]   vram_wdata_q, vram_wdata_d;
  logic          rd0_q, rd0_d, rd1_q, rd1_d;
  logic [15:0]   char_data_q, char_data_d;
  logic          char_valid_q, char_valid_d;

  logic          slot, pop, push;
  logic [8:0]    row;
  logic [15:0]   slot_addr;

`ifdef VRAM_SCROLL_EN
  logic [8:0] row_sum;
  always_comb begin
    row_sum = {1'b0, y[10:3]} + {3'b0, scroll_row};
    // Single conditional subtract is enough because scroll_row < ROWS.
    row = (row_sum >= 9'(ROWS)) ? (row_sum - 9'(ROWS)) : row_sum;
  end
`else
  assign row = {1'b0, y[10:3]};
`endif

  always_comb begin
    slot      = (x < H_ACT_W) && (y < V_ACT_W) && (x[2:0] == 3'd0);
    slot_addr = (16'(row) * COLS_W) + 16'(x[10:3]);
    // Pop is decided from the registered count, so a push into an empty
    // FIFO is never written in the same cycle.
    pop       = !slot && (count_q != '0);
    push      = cpu_we && ((count_q != CNT_FULL) || pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (cpu_we && !push);

    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    vram_we_d    = 1'b0;
    if (slot) begin
      vram_addr_d = slot_addr;
    end else if (pop) begin
      vram_addr_d  = addr_mem[rd_ptr_q];
      vram_wdata_d = data_mem[rd_ptr_q];
      vram_we_d    = 1'b1;
    end

    // Two-stage delay: address registered at E0, VRAM data valid after E1,
    // captured at E2.
    rd0_d        = slot;
    rd1_d        = rd0_q;
    char_valid_d = rd1_q;
    char_data_d  = rd1_q ? vram_rdata : char_data_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= cpu_waddr;
      data_mem[wr_ptr_q] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
      rd0_q        <= 1'b0;
      rd1_q        <= 1'b0;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
    end
  end

  assign cpu_full   = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign overflow   = overflow_q;
  assign vram_addr  = vram_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;
  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_waddr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] vram_rdata = '0;
`ifdef VRAM_SCROLL_EN
  logic [5:0]  scroll_row = '0;
`endif

  logic        full_a, empty_a, ovf_a, we_a, cv_a;
  logic [15:0] addr_a, wdata_a, cd_a;
  logic        full_b, empty_b, ovf_b, we_b, cv_b;
  logic [15:0] addr_b, wdata_b, cd_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_full(full_a), .fifo_empty(empty_a), .overflow(ovf_a),
    .vram_addr(addr_a), .vram_we(we_a), .vram_wdata(wdata_a),
    .vram_rdata(vram_rdata), .char_data(cd_a),
`ifdef VRAM_SCROLL_EN
    .scroll_row(scroll_row),
`endif
    .char_valid(cv_a)
  );

  vram_arbiter #(.FIFO_DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_full(full_b), .fifo_empty(empty_b), .overflow(ovf_b),
    .vram_addr(addr_b), .vram_we(we_b), .vram_wdata(wdata_b),
    .vram_rdata(vram_rdata), .char_data(cd_b),
`ifdef VRAM_SCROLL_EN
    .scroll_row(scroll_row),
`endif
    .char_valid(cv_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({addr_a, we_a, wdata_a, cd_a, cv_a, full_a, empty_a, ovf_a} !== {16'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_a: got addr=%0d we=%b wdata=%h cd=%h cv=%b full=%b empty=%b ovf=%b, want 0 0 0 0 0 0 1 0",
               addr_a, we_a, wdata_a, cd_a, cv_a, full_a, empty_a, ovf_a);
    end
    checks++;
    if ({addr_b, we_b, full_b, empty_b, ovf_b, cv_b} !== {16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_b: got addr=%0d we=%b full=%b empty=%b ovf=%b cv=%b", addr_b, we_b, full_b, empty_b, ovf_b, cv_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_addr_map();
    y = 11'd8; x = 11'd16;
    step();                                   // E0
    checks++;
    if (addr_a !== 16'd82 || we_a !== 1'b0) begin
      failures++; $display("FAIL addr_82: got addr=%0d we=%b, want 82 0", addr_a, we_a);
    end
    x = 11'd17; vram_rdata = 16'hABCD;
    step();                                   // E1
    checks++;
    if (cv_a !== 1'b0) begin failures++; $display("FAIL cv_early: got %b want 0", cv_a); end
    x = 11'd18;
    step();                                   // E2
    checks++;
    if (cv_a !== 1'b1 || cd_a !== 16'hABCD) begin
      failures++; $display("FAIL char_e2: got cv=%b cd=%h, want 1 abcd", cv_a, cd_a);
    end
    vram_rdata = 16'h1111; x = 11'd19;
    step();
    checks++;
    if (cv_a !== 1'b0 || cd_a !== 16'hABCD) begin
      failures++; $display("FAIL char_hold: got cv=%b cd=%h, want 0 abcd", cv_a, cd_a);
    end
    y = 11'd479; x = 11'd632;
    step();
    checks++;
    if (addr_a !== 16'd4799 || we_a !== 1'b0) begin
      failures++; $display("FAIL addr_4799: got addr=%0d we=%b, want 4799 0", addr_a, we_a);
    end
    x = 11'd633; step(); x = 11'd634; step();
    checks++;
    if (cv_a !== 1'b1 || cd_a !== 16'h1111) begin
      failures++; $display("FAIL char_last: got cv=%b cd=%h, want 1 1111", cv_a, cd_a);
    end
  endtask

  task automatic test_blanking();
    y = 11'd480; x = 11'd0;
    cpu_we = 1'b1; cpu_waddr = 16'h0010; cpu_wdata = 16'h0741;
    step();                                   // push accepted
    cpu_we = 1'b0;
    checks++;
    if (we_a !== 1'b0 || empty_a !== 1'b0 || cv_a !== 1'b0) begin
      failures++; $display("FAIL blank_push: got we=%b empty=%b cv=%b, want 0 0 0", we_a, empty_a, cv_a);
    end
    step();
    checks++;
    if (we_a !== 1'b1 || addr_a !== 16'h0010 || wdata_a !== 16'h0741 || empty_a !== 1'b1) begin
      failures++; $display("FAIL blank_write: got we=%b addr=%h wdata=%h empty=%b, want 1 0010 0741 1",
                           we_a, addr_a, wdata_a, empty_a);
    end
    step();
    checks++;
    if (we_a !== 1'b0 || addr_a !== 16'h0010 || cv_a !== 1'b0) begin
      failures++; $display("FAIL blank_idle: got we=%b addr=%h cv=%b, want 0 0010 0", we_a, addr_a, cv_a);
    end
  endtask

  task automatic test_write_vs_slot();
    y = 11'd8; x = 11'd7;
    cpu_we = 1'b1; cpu_waddr = 16'h0100; cpu_wdata = 16'h0001;
    step();                                   // A
    checks++;
    if (we_a !== 1'b0 || full_b !== 1'b1 || full_a !== 1'b0) begin
      failures++; $display("FAIL wvs_A: got we_a=%b full_b=%b full_a=%b, want 0 1 0", we_a, full_b, full_a);
    end
    x = 11'd8; cpu_waddr = 16'h0101; cpu_wdata = 16'h0002;
    step();                                   // B: slot
    cpu_we = 1'b0;
    checks++;
    if (addr_a !== 16'd81 || we_a !== 1'b0 || ovf_a !== 1'b0 || ovf_b !== 1'b1) begin
      failures++; $display("FAIL wvs_B: got addr=%0d we=%b ovf_a=%b ovf_b=%b, want 81 0 0 1", addr_a, we_a, ovf_a, ovf_b);
    end
    x = 11'd9;
    step();                                   // C
    checks++;
    if (we_a !== 1'b1 || addr_a !== 16'h0100 || wdata_a !== 16'h0001) begin
      failures++; $display("FAIL wvs_C_a: got we=%b addr=%h wdata=%h, want 1 0100 0001", we_a, addr_a, wdata_a);
    end
    checks++;
    if (we_b !== 1'b1 || addr_b !== 16'h0100 || full_b !== 1'b0) begin
      failures++; $display("FAIL wvs_C_b: got we=%b addr=%h full=%b, want 1 0100 0", we_b, addr_b, full_b);
    end
    x = 11'd10;
    step();                                   // D
    checks++;
    if (we_a !== 1'b1 || addr_a !== 16'h0101 || wdata_a !== 16'h0002) begin
      failures++; $display("FAIL wvs_D_a: got we=%b addr=%h wdata=%h, want 1 0101 0002", we_a, addr_a, wdata_a);
    end
    checks++;
    if (we_b !== 1'b0 || addr_b !== 16'h0100) begin
      failures++; $display("FAIL wvs_D_b: got we=%b addr=%h, want 0 0100", we_b, addr_b);
    end
    x = 11'd11;
    step();
    step();
    checks++;
    if (we_a !== 1'b0 || addr_a !== 16'h0101 || ovf_a !== 1'b0 || ovf_b !== 1'b1) begin
      failures++; $display("FAIL wvs_E: got we=%b addr=%h ovf_a=%b ovf_b=%b, want 0 0101 0 1", we_a, addr_a, ovf_a, ovf_b);
    end
  endtask

`ifdef VRAM_SCROLL_EN
  task automatic test_scroll();
    y = 11'd440; x = 11'd24; scroll_row = 6'd5;
    step();
    checks++;
    if (addr_a !== 16'd3) begin failures++; $display("FAIL scroll_5: got %0d want 3", addr_a); end
    scroll_row = 6'd0;
    step();
    checks++;
    if (addr_a !== 16'd4403) begin failures++; $display("FAIL scroll_0: got %0d want 4403", addr_a); end
    x = 11'd25;
    step(); step(); step();
  endtask
`endif

  task automatic test_reset_mid();
    y = 11'd16;
    cpu_we = 1'b1;
    for (int i = 7; i <= 16; i++) begin
      x = 11'(i); cpu_waddr = 16'(16'h0200 + i); cpu_wdata = 16'(i);
      step();
    end
    cpu_we = 1'b0; x = 11'd17;
    checks++;
    if (empty_a !== 1'b0 || full_a !== 1'b0 || ovf_b !== 1'b1) begin
      failures++; $display("FAIL mid_pending: got empty=%b full=%b ovf_b=%b, want 0 0 1", empty_a, full_a, ovf_b);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({addr_a, we_a, wdata_a, cd_a, cv_a, full_a, empty_a, ovf_a, ovf_b} !==
        {16'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got addr=%0d we=%b wdata=%h cd=%h cv=%b full=%b empty=%b ovf_a=%b ovf_b=%b",
               addr_a, we_a, wdata_a, cd_a, cv_a, full_a, empty_a, ovf_a, ovf_b);
    end
    #1 rst = 1'b0;
    y = 11'd480;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (we_a !== 1'b0 || cv_a !== 1'b0 || empty_a !== 1'b1) begin
        failures++; $display("FAIL post_reset_%0d: got we=%b cv=%b empty=%b, want 0 0 1", i, we_a, cv_a, empty_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_map();
    test_blanking();
    test_write_vs_slot();
`ifdef VRAM_SCROLL_EN
    test_scroll();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
